// File: rtl/button_bank.sv
// ----------------------------------------------------------------------------
// button_bank
//
// Multi-channel push-button conditioner. Each of NUM_BTN raw button inputs is
// synchronised, debounced and decoded into single-cycle press, release and
// long-press events. An optional auto-repeat event fires periodically while a
// button stays held after its long-press.
//
// Optional feature macro: BUTTON_BANK_AUTOREPEAT_EN
//   defined     -> per-channel repeat counter, repeat_pulse fires every
//                  REPEAT_CYCLES cycles after long_pulse until release
//   not defined -> no repeat counter, repeat_pulse tied to 0
//
// Ports
//   clk            in   1        system clock, rising edge
//   reset          in   1        asynchronous active-high reset, clears all state
//   button_in      in   NUM_BTN  raw asynchronous button levels (1 = pressed)
//   button_level   out  NUM_BTN  debounced level per channel
//   press_pulse    out  NUM_BTN  one-cycle pulse on accepted 0->1
//   release_pulse  out  NUM_BTN  one-cycle pulse on accepted 1->0
//   long_pulse     out  NUM_BTN  one-cycle pulse LONG_CYCLES after press_pulse
//   repeat_pulse   out  NUM_BTN  one-cycle auto-repeat pulse
// ----------------------------------------------------------------------------
module button_bank #(
    parameter int NUM_BTN         = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int LONG_CYCLES     = 50000,
    parameter int REPEAT_CYCLES   = 10000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] button_in,
    output logic [NUM_BTN-1:0] button_level,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [NUM_BTN-1:0] release_pulse,
    output logic [NUM_BTN-1:0] long_pulse,
    output logic [NUM_BTN-1:0] repeat_pulse
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

`ifdef BUTTON_BANK_AUTOREPEAT_EN
    // A period of 1 would give a zero-width counter, so keep at least one bit.
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_t;

    for (genvar g = 0; g < NUM_BTN; g++) begin : gChan

        logic [SYNC_STAGES-1:0] sync_q;
        logic                   syncOut;
        logic [DW-1:0]          debCnt_q, debCnt_d;
        logic                   stable_q, stable_d;
        logic                   rise, fall;
        state_t                 state_q, state_d;
        logic [HW-1:0]          hcnt_q, hcnt_d;
        logic                   press_q, press_d;
        logic                   release_q, release_d;
        logic                   long_q, long_d;
`ifdef BUTTON_BANK_AUTOREPEAT_EN
        logic [RW-1:0]          rcnt_q, rcnt_d;
        logic                   repeat_q, repeat_d;
`endif

        // Synchroniser chain: the raw pin enters at bit 0 and the
        // metastability-safe copy is taken from the last stage.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], button_in[g]};
            end
        end

        assign syncOut = sync_q[SYNC_STAGES-1];

        // Debounce: a new level is accepted only once the synchronised input
        // has disagreed with the stable level for DEBOUNCE_CYCLES edges in a
        // row; any agreement in between restarts the count.
        always_comb begin
            stable_d = stable_q;
            debCnt_d = debCnt_q;
            if (syncOut == stable_q) begin
                debCnt_d = '0;
            end else if (debCnt_q == DEB_LAST) begin
                stable_d = syncOut;
                debCnt_d = '0;
            end else begin
                debCnt_d = debCnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stable_q <= 1'b0;
                debCnt_q <= '0;
            end else begin
                stable_q <= stable_d;
                debCnt_q <= debCnt_d;
            end
        end

        // The FSM looks at the level being committed on this edge, so the
        // registered event pulses line up with the first cycle of the new
        // debounced level.
        assign rise = stable_d & ~stable_q;
        assign fall = ~stable_d & stable_q;

        // Event FSM. A release always wins: when the hold limit (or the
        // repeat period) expires on the same edge as a fall, only the
        // release is reported.
        always_comb begin
            state_d   = state_q;
            hcnt_d    = hcnt_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            long_d    = 1'b0;
`ifdef BUTTON_BANK_AUTOREPEAT_EN
            rcnt_d    = rcnt_q;
            repeat_d  = 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        press_d = 1'b1;
                        hcnt_d  = '0;
                        state_d = PRESSED;
                    end
                end
                PRESSED: begin
                    if (fall) begin
                        release_d = 1'b1;
                        state_d   = IDLE;
                    end else if (hcnt_q == HOLD_LAST) begin
                        long_d  = 1'b1;
                        state_d = HELD;
`ifdef BUTTON_BANK_AUTOREPEAT_EN
                        rcnt_d  = '0;
`endif
                    end else begin
                        hcnt_d = hcnt_q + 1'b1;
                    end
                end
                HELD: begin
                    if (fall) begin
                        release_d = 1'b1;
                        state_d   = IDLE;
`ifdef BUTTON_BANK_AUTOREPEAT_EN
                        rcnt_d    = '0;
`endif
                    end
`ifdef BUTTON_BANK_AUTOREPEAT_EN
                    else if (rcnt_q == REP_LAST) begin
                        repeat_d = 1'b1;
                        rcnt_d   = '0;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
`endif
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // FSM state, hold counter and registered event outputs.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q   <= IDLE;
                hcnt_q    <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                hcnt_q    <= hcnt_d;
                press_q   <= press_d;
                release_q <= release_d;
                long_q    <= long_d;
            end
        end

`ifdef BUTTON_BANK_AUTOREPEAT_EN
        // Repeat counter and its registered pulse.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rcnt_q   <= '0;
                repeat_q <= 1'b0;
            end else begin
                rcnt_q   <= rcnt_d;
                repeat_q <= repeat_d;
            end
        end

        assign repeat_pulse[g] = repeat_q;
`endif

        assign button_level[g]  = stable_q;
        assign press_pulse[g]   = press_q;
        assign release_pulse[g] = release_q;
        assign long_pulse[g]    = long_q;
    end

`ifndef BUTTON_BANK_AUTOREPEAT_EN
    assign repeat_pulse = '0;
`endif

endmodule
